mem_lsu: RTL and testbench

CPU-side load/store initiator for the word-organised data memory (2048 × 32-bit, byte-enable writes, combinational read). Accepts one load or store per handshake from the MEM stage, checks alignment, drives the memory port (read/write enables, address, data, byte enables) for exactly one cycle, then returns a registered, lane-extracted and sign/zero-extended load result or a store completion. Sits between the pipeline MEM stage and the data memory; misaligned accesses return address-error exceptions without touching memory.

---
 rtl/mem_lsu_pkg.sv | 78 +++++++
 rtl/mem_lsu_load_extend.sv | 34 +++
 rtl/mem_lsu.sv | 132 +++++++++++++
 tb/tb_mem_lsu.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the load/store unit: op codes, FSM states,
// exception codes, byte-enable patterns and small decode helpers.
// The data memory decodes DM_ADDR_BITS byte-address bits; any higher bits
// pass straight through to MemAddr and simply alias in the memory.
package mem_lsu_pkg;

  localparam int DM_ADDR_BITS = 13;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_BYTE1   = 4'b0010;
  localparam logic [3:0] BE_BYTE2   = 4'b0100;
  localparam logic [3:0] BE_BYTE3   = 4'b1000;

  function automatic logic op_is_store(input lsu_op_e op);
    logic res;
    case (op)
      OP_SW, OP_SH, OP_SB: res = 1'b1;
      default:             res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic op_misaligned(input lsu_op_e op, input logic [1:0] lo);
    logic res;
    case (op)
      OP_LW, OP_SW:         res = (lo != 2'b00);
      OP_LH, OP_LHU, OP_SH: res = lo[0];
      default:              res = 1'b0;
    endcase
    return res;
  endfunction

  // Only the three store widths produce enables; loads never assert BE.
  function automatic logic [3:0] op_byte_enable(input lsu_op_e op, input logic [1:0] lo);
    logic [3:0] res;
    case (op)
      OP_SW: res = BE_WORD;
      OP_SH: res = lo[1] ? BE_HALF_HI : BE_HALF_LO;
      OP_SB: begin
        case (lo)
          2'b00:   res = BE_BYTE0;
          2'b01:   res = BE_BYTE1;
          2'b10:   res = BE_BYTE2;
          2'b11:   res = BE_BYTE3;
          default: res = BE_NONE;
        endcase
      end
      default: res = BE_NONE;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_lsu_load_extend.sv
// Lane extraction and sign/zero extension of a memory read word.
module lsu_load_extend
  import mem_lsu_pkg::*;
(
  input  lsu_op_e     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [15:0] half_s;
  logic [7:0]  lane_s;

  // Select the addressed half/byte lane and extend it according to the op
  always_comb begin
    half_s = addr_lo[1] ? word[31:16] : word[15:0];
    case (addr_lo)
      2'b00:   lane_s = word[7:0];
      2'b01:   lane_s = word[15:8];
      2'b10:   lane_s = word[23:16];
      2'b11:   lane_s = word[31:24];
      default: lane_s = 8'h00;
    endcase
    case (op)
      OP_LW:   result = word;
      OP_LH:   result = {{16{half_s[15]}}, half_s};
      OP_LHU:  result = {16'h0000, half_s};
      OP_LB:   result = {{24{lane_s[7]}}, lane_s};
      OP_LBU:  result = {24'h000000, lane_s};
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator: accepts one request, checks alignment, drives the
// data-memory port for exactly one cycle and returns a registered response.
// Every output is a flop, so nothing on req_* reaches Mem* combinationally.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_exc,
  output logic [4:0]  rsp_exc_code,
  output logic [31:0] rsp_badaddr,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] MemAddr,
  output logic [31:0] MemData,
  output logic [3:0]  BE,
  input  logic [31:0] ReadData
);

  lsu_state_e  state_r;
  lsu_op_e     op_r;
  logic [1:0]  addr_lo_r;
  lsu_op_e     req_op_s;
  logic        req_store_s;
  logic        req_misaligned_s;
  logic [31:0] load_ext_s;

  assign req_op_s         = lsu_op_e'(req_op);
  assign req_store_s      = op_is_store(req_op_s);
  assign req_misaligned_s = op_misaligned(req_op_s, req_addr[1:0]);

  lsu_load_extend u_load_extend (
    .op      (op_r),
    .addr_lo (addr_lo_r),
    .word    (ReadData),
    .result  (load_ext_s)
  );

  // Request/access/response sequencing with all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      op_r         <= OP_LW;
      addr_lo_r    <= 2'b00;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'h0000_0000;
      rsp_exc      <= 1'b0;
      rsp_exc_code <= EXC_NONE;
      rsp_badaddr  <= 32'h0000_0000;
      MemRead      <= 1'b0;
      MemWrite     <= 1'b0;
      MemAddr      <= 32'h0000_0000;
      MemData      <= 32'h0000_0000;
      BE           <= BE_NONE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            op_r      <= req_op_s;
            addr_lo_r <= req_addr[1:0];
            req_ready <= 1'b0;
            if (req_misaligned_s) begin
              // Address error: answer directly, memory is never touched
              state_r      <= ST_RESP;
              rsp_valid    <= 1'b1;
              rsp_rdata    <= 32'h0000_0000;
              rsp_exc      <= 1'b1;
              rsp_exc_code <= req_store_s ? EXC_ADES : EXC_ADEL;
              rsp_badaddr  <= req_addr;
            end else begin
              // Data goes out unshifted; the memory steers half/byte lanes
              state_r  <= ST_ACCESS;
              MemRead  <= ~req_store_s;
              MemWrite <= req_store_s;
              MemAddr  <= req_addr;
              MemData  <= req_wdata;
              BE       <= op_byte_enable(req_op_s, req_addr[1:0]);
            end
          end
        end
        ST_ACCESS: begin
          state_r      <= ST_RESP;
          MemRead      <= 1'b0;
          MemWrite     <= 1'b0;
          MemAddr      <= 32'h0000_0000;
          MemData      <= 32'h0000_0000;
          BE           <= BE_NONE;
          rsp_valid    <= 1'b1;
          rsp_rdata    <= op_is_store(op_r) ? 32'h0000_0000 : load_ext_s;
          rsp_exc      <= 1'b0;
          rsp_exc_code <= EXC_NONE;
          rsp_badaddr  <= 32'h0000_0000;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_r      <= ST_IDLE;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'h0000_0000;
            rsp_exc      <= 1'b0;
            rsp_exc_code <= EXC_NONE;
            rsp_badaddr  <= 32'h0000_0000;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          req_ready    <= 1'b1;
          rsp_valid    <= 1'b0;
          rsp_rdata    <= 32'h0000_0000;
          rsp_exc      <= 1'b0;
          rsp_exc_code <= EXC_NONE;
          rsp_badaddr  <= 32'h0000_0000;
          MemRead      <= 1'b0;
          MemWrite     <= 1'b0;
          MemAddr      <= 32'h0000_0000;
          MemData      <= 32'h0000_0000;
          BE           <= BE_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: a word-organised data memory is modelled
// around the DUT, and a byte-addressed reference memory predicts results.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int NWORDS = 1 << (DM_ADDR_BITS - 2);
  localparam int NBYTES = 1 << DM_ADDR_BITS;

  logic        clk = 1'b0;
  logic        reset, preload;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_exc;
  logic [4:0]  rsp_exc_code;
  logic [31:0] rsp_badaddr;
  logic        MemRead, MemWrite;
  logic [31:0] MemAddr, MemData, ReadData;
  logic [3:0]  BE;

  logic [31:0] dm [0:NWORDS-1];
  logic [7:0]  ref_mem [0:NBYTES-1];

  int checks = 0;
  int failures = 0;

  mem_lsu dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_exc(rsp_exc), .rsp_exc_code(rsp_exc_code), .rsp_badaddr(rsp_badaddr),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemAddr(MemAddr),
    .MemData(MemData), .BE(BE), .ReadData(ReadData)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
  endfunction

  // Data memory: combinational read, byte-lane writes, reset blocks writes
  assign ReadData = dm[MemAddr[DM_ADDR_BITS-1:2]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NWORDS; i++) dm[i] <= pat(i);
    end else if (!reset && MemWrite) begin
      case (BE)
        4'b0011: dm[MemAddr[DM_ADDR_BITS-1:2]][15:0]  <= MemData[15:0];
        4'b1100: dm[MemAddr[DM_ADDR_BITS-1:2]][31:16] <= MemData[15:0];
        4'b0001: dm[MemAddr[DM_ADDR_BITS-1:2]][7:0]   <= MemData[7:0];
        4'b0010: dm[MemAddr[DM_ADDR_BITS-1:2]][15:8]  <= MemData[7:0];
        4'b0100: dm[MemAddr[DM_ADDR_BITS-1:2]][23:16] <= MemData[7:0];
        4'b1000: dm[MemAddr[DM_ADDR_BITS-1:2]][31:24] <= MemData[7:0];
        default: dm[MemAddr[DM_ADDR_BITS-1:2]]        <= MemData;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic int op_size(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd5) return 4;
    if (op == 3'd1 || op == 3'd2 || op == 3'd6) return 2;
    return 1;
  endfunction

  // Reference load: little-endian byte gather, then extend by access width
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
    int base, size;
    logic [63:0] v;
    base = int'(a[DM_ADDR_BITS-1:0]);
    size = op_size(op);
    v = 64'd0;
    for (int k = 0; k < size; k++) v = v | (64'(ref_mem[base + k]) << (8 * k));
    if ((op == 3'd1 || op == 3'd3) && v[8 * size - 1])
      v = v | ~((64'd1 << (8 * size)) - 64'd1);
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    int base;
    base = int'(a[DM_ADDR_BITS-1:0]);
    for (int k = 0; k < op_size(op); k++) ref_mem[base + k] = 8'(wd >> (8 * k));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_exc"}, 32'(rsp_exc), 32'd0);
    chk({tag, "_exc_code"}, 32'(rsp_exc_code), 32'd0);
    chk({tag, "_badaddr"}, rsp_badaddr, 32'd0);
    chk({tag, "_mem_en"}, {30'd0, MemRead, MemWrite}, 32'd0);
    chk({tag, "_be"}, 32'(BE), 32'd0);
    chk({tag, "_memaddr"}, MemAddr, 32'd0);
    chk({tag, "_memdata"}, MemData, 32'd0);
  endtask

  // One full transaction, entered and left on a falling edge with DUT idle
  task automatic do_req(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input int hold);
    logic st, mis;
    int size;
    logic [31:0] exp_rd, exp_be;
    st = (op >= 3'd5);
    size = op_size(op);
    mis = (int'(a[1:0]) % size) != 0;
    exp_rd = (!mis && !st) ? ref_load(op, a) : 32'd0;
    exp_be = st ? ((32'd1 << size) - 32'd1) << a[1:0] : 32'd0;
    chk({tag, "_ready_in"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    rsp_ready = (hold == 0);
    @(negedge clk);
    req_valid = 1'b0;
    if (mis) begin
      chk({tag, "_no_access"}, {30'd0, MemRead, MemWrite}, 32'd0);
      chk({tag, "_no_be"}, 32'(BE), 32'd0);
    end else begin
      chk({tag, "_memread"}, 32'(MemRead), 32'(!st));
      chk({tag, "_memwrite"}, 32'(MemWrite), 32'(st));
      chk({tag, "_be"}, 32'(BE), exp_be);
      chk({tag, "_memaddr"}, MemAddr, a);
      chk({tag, "_memdata"}, MemData, wd);
      chk({tag, "_rsp_early"}, 32'(rsp_valid), 32'd0);
      @(negedge clk);
      if (st) ref_store(op, a, wd);
    end
    for (int c = 0; c <= hold; c++) begin
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_rdata"}, rsp_rdata, exp_rd);
      chk({tag, "_exc"}, 32'(rsp_exc), 32'(mis));
      chk({tag, "_code"}, 32'(rsp_exc_code), mis ? (st ? 32'd5 : 32'd4) : 32'd0);
      chk({tag, "_badaddr"}, rsp_badaddr, mis ? a : 32'd0);
      chk({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
      chk({tag, "_idle_port"}, {30'd0, MemRead, MemWrite}, 32'd0);
      if (c < hold) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_ready_out"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r, a;
    logic [2:0] op;
    reset = 1'b1; preload = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_op = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < NWORDS; i++)
      for (int k = 0; k < 4; k++) ref_mem[4 * i + k] = 8'(pat(i) >> (8 * k));
    @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    chk_reset_vals("reset");
    @(negedge clk);
    reset = 1'b0;

    do_req("sw10", 3'd5, 32'h0000_0010, 32'h1234_5678, 0);
    do_req("lw10", 3'd0, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    do_req("sb13", 3'd7, 32'h0000_0013, 32'h0000_00AB, 0);
    do_req("lb13", 3'd3, 32'h0000_0013, 32'd0, 0);
    do_req("lbu13", 3'd4, 32'h0000_0013, 32'd0, 0);
    do_req("lw10b", 3'd0, 32'h0000_0010, 32'd0, 0);
    do_req("sh22", 3'd6, 32'h0000_0022, 32'h0000_8001, 0);
    do_req("lh22", 3'd1, 32'h0000_0022, 32'd0, 0);
    do_req("lhu22", 3'd2, 32'h0000_0022, 32'd0, 0);
    do_req("lw11", 3'd0, 32'h0000_0011, 32'd0, 0);
    do_req("sh21", 3'd6, 32'h0000_0021, 32'h0000_FFFF, 0);
    do_req("lw20", 3'd0, 32'h0000_0020, 32'd0, 0);
    do_req("lwhold", 3'd0, 32'h0000_0010, 32'd0, 5);

    // Reset arriving during the ACCESS cycle of a store
    req_valid = 1'b1; req_op = 3'd5; req_addr = 32'h0000_0030; req_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_acc_memwrite", 32'(MemWrite), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("rst_acc");
    @(negedge clk);
    chk("rst_acc_no_rsp", 32'(rsp_valid), 32'd0);
    do_req("lw30", 3'd0, 32'h0000_0030, 32'd0, 0);

    // Request presented together with reset is ignored
    reset = 1'b1; req_valid = 1'b1; req_op = 3'd0; req_addr = 32'h0000_0040;
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    chk_reset_vals("rst_req");

    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      r = $urandom;
      a = r & 32'h0000_603F;
      do_req("rand", op, a, $urandom, int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
